// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath width, fetch FSM states, fault filler word
// and the payload held by the fetch output buffer.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  // Word handed to decode in place of a faulting fetch (addi x0, x0, 0).
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory valid/ready bus between the fetch stage and imem.
//   master (fetch): drives request valid/addr, receives ready and the response.
//   slave  (imem) : the mirror image.
interface inst_fetch_if;
  import cpu_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            imem_rsp_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
  );

endinterface

// File: rtl/inst_buf.sv
// One-entry valid/ready holding register for a fetched instruction.
//   load    : capture d and set valid
//   consume : decode took the entry (clears valid unless reloaded)
//   clear   : flush, wins over load and consume
//   valid/q : registered buffer state
module inst_buf
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         consume,
  input  logic         clear,
  input  fetch_entry_t d,
  output logic         valid,
  output fetch_entry_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: accepts a fetch address, issues a single imem
// request, and parks the returned word in a one-entry buffer for decode.
// Handles redirect flushes (in-flight responses are dropped) and misaligned
// addresses (faulted NOP, no memory access).
//   clk, rst_n            : clock, async active-low reset
//   pc_i/pc_valid/pc_ready: fetch address handshake
//   flush                 : redirect, abandons pending fetch and buffer
//   imem                  : instruction memory bus (master side)
//   inst_*                : buffered instruction towards decode
//   busy                  : a memory transaction is in progress
module inst_fetch
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            flush,
  inst_fetch_if.master    imem,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_fault_o,
  output logic            busy
);

  fetch_state_t    state;
  logic            drop_pend;
  logic            req_valid;
  logic [XLEN-1:0] req_addr;

  logic            pc_accept;
  logic            pc_misaligned;
  logic            rsp_load;
  logic            mis_load;
  fetch_entry_t    buf_d;
  fetch_entry_t    buf_q;

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = req_addr;

  assign pc_ready      = (state == IDLE) & ~flush & (~inst_valid | inst_ready);
  assign pc_accept     = pc_valid & pc_ready;
  assign pc_misaligned = (pc_i[1:0] != 2'b00);
  assign busy          = (state != IDLE);

  // A response in WAIT is only kept if no redirect arrives alongside it.
  assign rsp_load = (state == WAIT) & imem.imem_rsp_valid & ~flush;
  assign mis_load = pc_accept & pc_misaligned;

  // Buffer payload: memory response, otherwise the misaligned-fault filler.
  always_comb begin
    buf_d.inst  = NOP_INST;
    buf_d.pc    = pc_i;
    buf_d.fault = 1'b1;
    if (rsp_load) begin
      buf_d.inst  = imem.imem_rsp_data;
      buf_d.pc    = req_addr;
      buf_d.fault = imem.imem_rsp_err;
    end
  end

  // Fetch FSM with request register and pending-drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drop_pend <= 1'b0;
      req_valid <= 1'b0;
      req_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_accept && !pc_misaligned) begin
            req_addr  <= pc_i;
            req_valid <= 1'b1;
            drop_pend <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          // Request must complete even when flushed; remember to drop its reply.
          if (imem.imem_req_ready) begin
            req_valid <= 1'b0;
            drop_pend <= 1'b0;
            state     <= (flush || drop_pend) ? DROP : WAIT;
          end else if (flush) begin
            drop_pend <= 1'b1;
          end
        end
        WAIT: begin
          if (imem.imem_rsp_valid) begin
            state <= IDLE;
          end else if (flush) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (imem.imem_rsp_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  inst_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (rsp_load | mis_load),
    .consume (inst_valid & inst_ready),
    .clear   (flush),
    .d       (buf_d),
    .valid   (inst_valid),
    .q       (buf_q)
  );

  assign inst_o       = buf_q.inst;
  assign inst_pc_o    = buf_q.pc;
  assign inst_fault_o = buf_q.fault;

endmodule
